even_parity_checker_rx: RTL and testbench
=========================================

Name: even_parity_checker_rx

Overview:
Serial receiver and checker for even-parity frames from our even-parity generators. It accepts a bit-serial stream of DATA_W data bits (LSB first) followed by one even-parity bit, and deserialises the data. It checks that the XOR of all DATA_W+1 received bits is 0, then presents the parallel word with a valid pulse and an error flag. It sits at the receive end of the parity-protected link, feeding downstream logic that consumes data_out/out_vld.

Parameters:
DATA_W, 3, number of data bits per frame (legal range 1..32); the parity bit is extra.
CNT_W, 8, width of the optional parity-error counter.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
sin  input  1  serial data/parity bit
sin_vld  input  1  sin is sampled only when high; a low cycle stalls the frame
sof  input  1  start of frame; qualified by sin_vld; marks sin as data bit 0
data_out  output  DATA_W  received data word; held until the next frame completes
out_vld  output  1  one-cycle pulse when data_out/par_err update
par_err  output  1  1 = odd parity received (error); valid with out_vld, held until next completion
busy  output  1  high while a frame is in progress (state != IDLE)
err_cnt  output  CNT_W  saturating count of frames with par_err=1 (present only with PARITY_ERR_CNT_EN)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, bit counter=0, shift register=0, running parity=0. Outputs: data_out=0, out_vld=0, par_err=0, busy=0, err_cnt=0. Reset overrides all other inputs. Reset mid-frame discards the partial frame with no out_vld.
- States: IDLE, DATA, PARITY.
  - IDLE: on sin_vld&sof, load sin into bit 0, set parity to sin and count to 1. Go to DATA, or to PARITY if DATA_W=1. sin_vld without sof is ignored.
  - DATA: on each sin_vld, shift sin into bit [count] (LSB first), update parity ^= sin and increment count. When count reaches DATA_W, go to PARITY.
  - PARITY: on sin_vld, par_err <= parity^sin, data_out <= the assembled word, out_vld <= 1 on the next cycle, and go to IDLE.
- Latency: out_vld is high in the cycle after the edge that samples the parity bit. It is never high for two consecutive cycles.
- Stalls: sin_vld=0 holds state, count and parity unchanged, with no timeout.
- sof asserted while in DATA or PARITY (with sin_vld): abort the current frame silently (no out_vld) and restart as if from IDLE using this sin as bit 0.
- Back-to-back frames: sof with sin_vld in the cycle immediately after the parity bit is accepted (the FSM is already in IDLE).
- data_out and par_err change only on completion. Between completions they hold their last values.
- busy=1 in DATA and PARITY, 0 in IDLE.

Optional Feature:
Macro PARITY_ERR_CNT_EN.
- Defined: the err_cnt port exists. It increments by 1 in the same cycle par_err is registered as 1 and saturates at 2^CNT_W-1 (no wrap). It is cleared only by rst.
- Undefined: the err_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- DATA_W=3. Send sof+1,0,1 then parity 0, all with sin_vld=1 -> one cycle later out_vld=1, data_out=3'b101, par_err=0, busy falls to 0.
- Send 1,1,1 then parity 0 -> data_out=3'b111, par_err=1, err_cnt increments 0->1 (macro on). Send 1,1,1 with parity 1 -> par_err=0, err_cnt stays 1.
- Frame 0,1,1, parity 0, with sin_vld=0 for 2 cycles between every bit -> same result as unstalled (data_out=3'b110, par_err=0), exactly one out_vld pulse.
- Send sof+1,1, then sof+0,0,1, parity 1 -> no out_vld for the aborted frame; one pulse with data_out=3'b100, par_err=0.
- Assert rst after 2 data bits -> busy=0 and outputs at reset values next cycle. Then a full frame 0,0,1/parity 1 completes normally.
- CNT_W=2, macro on: send 5 consecutive bad-parity frames back-to-back -> err_cnt sequence 1,2,3,3,3. par_err=1 on each out_vld.

Source files
------------

// File: rtl/even_parity_checker_rx.sv
// Bit-serial even-parity frame receiver: DATA_W data bits LSB first, then one parity bit.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module even_parity_checker_rx #(
    parameter int unsigned DATA_W = 32'd3,
    parameter int unsigned CNT_W  = 32'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_vld,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              out_vld,
    output logic              par_err,
    output logic              busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    if ((DATA_W < 32'd1) || (DATA_W > 32'd32) || (CNT_W < 32'd1)) begin : g_bad_param
        $error("even_parity_checker_rx: DATA_W must be 1..32 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] shift_r;
    // One-hot pointer to the data bit the next accepted sample lands in.
    logic [DATA_W-1:0] pos_r;
    logic              par_r;

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
`endif

    function automatic logic par_fold(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // Frame FSM, deserialiser, running parity and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            shift_r  <= {DATA_W{1'b0}};
            pos_r    <= {DATA_W{1'b0}};
            par_r    <= 1'b0;
            data_out <= {DATA_W{1'b0}};
            out_vld  <= 1'b0;
            par_err  <= 1'b0;
            busy     <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
            err_cnt  <= {CNT_W{1'b0}};
`endif
        end else begin
            out_vld <= 1'b0;
            if (sin_vld) begin
                if (sof) begin
                    // sof always (re)starts a frame; any partial frame is dropped silently.
                    shift_r <= DATA_W'(sin);
                    pos_r   <= DATA_W'(2'b10);
                    par_r   <= sin;
                    busy    <= 1'b1;
                    state_r <= (DATA_W == 32'd1) ? ST_PARITY : ST_DATA;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            state_r <= ST_IDLE;
                        end
                        ST_DATA: begin
                            shift_r <= (shift_r & ~pos_r) | (pos_r & {DATA_W{sin}});
                            pos_r   <= pos_r << 1'b1;
                            par_r   <= par_fold(par_r, sin);
                            if (pos_r[DATA_W-1]) begin
                                state_r <= ST_PARITY;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                        ST_PARITY: begin
                            data_out <= shift_r;
                            par_err  <= par_fold(par_r, sin);
                            out_vld  <= 1'b1;
                            busy     <= 1'b0;
                            state_r  <= ST_IDLE;
`ifdef PARITY_ERR_CNT_EN
                            if (par_fold(par_r, sin) && (err_cnt != ERR_MAX)) begin
                                err_cnt <= err_cnt + CNT_W'(1'b1);
                            end else begin
                                err_cnt <= err_cnt;
                            end
`endif
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_even_parity_checker_rx.sv
// Scoreboard bench for even_parity_checker_rx: frame-level reference model plus an independent output monitor.
module tb_even_parity_checker_rx;
    localparam int DW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sin;
    logic          sin_vld;
    logic          sof;
    logic [DW-1:0] data_out;
    logic          out_vld;
    logic          par_err;
    logic          busy;
`ifdef PARITY_ERR_CNT_EN
    logic [CW-1:0] err_cnt;
`endif

    even_parity_checker_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .sin_vld  (sin_vld),
        .sof      (sof),
        .data_out (data_out),
        .out_vld  (out_vld),
        .par_err  (par_err),
        .busy     (busy)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    exp_t          exp_q[$];
    bit            fr[$];
    bit            inframe = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_e = 1'b0;
    bit            mon_en = 1'b0;
    bit            prev_vld = 1'b0;
    int            tests = 0;
    int            failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect accepted bits of a frame; DW+1 of them form a completed frame.
    function automatic void model_accept(input bit s, input bit b);
        if (s) begin
            fr.delete();
            fr.push_back(b);
            inframe = 1'b1;
        end else if (inframe) begin
            fr.push_back(b);
            if (fr.size() == DW + 1) begin
                exp_t e;
                int   ones;
                int   word;
                ones = 0;
                word = 0;
                for (int i = 0; i <= DW; i++) ones += int'(fr[i]);
                for (int i = 0; i < DW; i++) word += int'(fr[i]) * (2 ** i);
                e.d = DW'(word);
                e.e = 1'((ones % 2) == 1);
                if (e.e && (m_cnt < (2 ** CW) - 1)) m_cnt++;
                exp_q.push_back(e);
                fr.delete();
                inframe = 1'b0;
            end
        end
    endfunction

    task automatic step(input logic r, input logic v, input logic s, input logic b);
        @(negedge clk);
        rst     = r;
        sin_vld = v;
        sof     = s;
        sin     = b;
        @(posedge clk);
        #1;
        if (r) begin
            fr.delete();
            inframe = 1'b0;
            m_cnt   = 0;
            hold_d  = '0;
            hold_e  = 1'b0;
        end else if (v) begin
            model_accept(s, b);
        end
        check("busy", int'(busy), int'(inframe));
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input int stall);
        for (int i = 0; i <= DW; i++) begin
            repeat (stall) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            if (i < DW) step(1'b0, 1'b1, (i == 0), d[i]);
            else        step(1'b0, 1'b1, 1'b0, p);
        end
    endtask

    // Monitor: pops the scoreboard on every out_vld and checks outputs hold otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (out_vld) begin
                    check("out_vld_consecutive", int'(prev_vld), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_vld", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out", int'(data_out), int'(e.d));
                        check("par_err", int'(par_err), int'(e.e));
                        hold_d = e.d;
                        hold_e = e.e;
                    end
                end else begin
                    check("data_out_hold", int'(data_out), int'(hold_d));
                    check("par_err_hold", int'(par_err), int'(hold_e));
                end
`ifdef PARITY_ERR_CNT_EN
                check("err_cnt", int'(err_cnt), m_cnt);
`endif
                prev_vld = out_vld;
            end
        end
    end

    initial begin
        logic [DW-1:0] rd;
        bit            r;
        bit            v;
        bit            s;
        rst = 1'b1; sin = 1'b0; sin_vld = 1'b0; sof = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        mon_en = 1'b1;

        send_frame(3'b101, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(3'b111, 1'b0, 0);
        send_frame(3'b111, 1'b1, 0);
        send_frame(3'b110, 1'b0, 2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(3'b100, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(3'b100, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            rd = DW'($urandom);
            send_frame(rd, ~(^rd), 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 249) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = inframe ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            step(r, v, s, 1'($urandom));
        end

        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
